rk_host_if: RTL

RK_HOST_IF -- requirements
Module: rk_host_if

---
 rtl/rk_pkg.sv | 43 ++++
 rtl/rk_cfg_bank.sv | 51 +++++
 rtl/rk_host_if.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rk_pkg.sv
// Shared types and frame layout for the RK solver host interface.
// Frame word offsets are derived from the stage count S so every block agrees on the layout.
package rk_pkg;

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        RUN      = 2'd1,
        SEND_Y   = 2'd2,
        SEND_CNT = 2'd3
    } rk_state_e;

    typedef enum logic [2:0] {
        F_A, F_B, F_C, F_K, F_X0, F_Y0, F_H0
    } rk_field_e;

    localparam int RK_S = 3;

    function automatic int frame_len(input int s);
        return s * s + 3 * s + 3;
    endfunction

    function automatic int field_ofs(input rk_field_e f, input int s);
        case (f)
            F_A:     return 0;
            F_B:     return s * s;
            F_C:     return s * s + s;
            F_K:     return s * s + 2 * s;
            F_X0:    return s * s + 3 * s;
            F_Y0:    return s * s + 3 * s + 1;
            F_H0:    return s * s + 3 * s + 2;
            default: return 0;
        endcase
    endfunction

    localparam int OFS_A  = field_ofs(F_A,  RK_S);
    localparam int OFS_B  = field_ofs(F_B,  RK_S);
    localparam int OFS_C  = field_ofs(F_C,  RK_S);
    localparam int OFS_K  = field_ofs(F_K,  RK_S);
    localparam int OFS_X0 = field_ofs(F_X0, RK_S);
    localparam int OFS_Y0 = field_ofs(F_Y0, RK_S);
    localparam int OFS_H0 = field_ofs(F_H0, RK_S);

endpackage

// File: rtl/rk_cfg_bank.sv
// Coefficient / initial-value register file, one word written per enabled cycle at index idx.
// Write lands on the next edge; no backpressure, indices past the frame are ignored.
module rk_cfg_bank
    import rk_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int S     = 3,
    parameter int IW    = 5
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    we,
    input  logic [IW-1:0]           idx,
    input  logic [WIDTH-1:0]        data,
    output logic signed [WIDTH-1:0] o_a [S*S],
    output logic signed [WIDTH-1:0] o_b [S],
    output logic signed [WIDTH-1:0] o_c [S],
    output logic signed [WIDTH-1:0] o_k [S],
    output logic signed [WIDTH-1:0] o_x0,
    output logic signed [WIDTH-1:0] o_y0,
    output logic signed [WIDTH-1:0] o_h0
);
    localparam int L  = frame_len(S);
    localparam int OB = field_ofs(F_B, S);
    localparam int OC = field_ofs(F_C, S);
    localparam int OK = field_ofs(F_K, S);

    logic [WIDTH-1:0] regs [L];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < L; i++) regs[i] <= '0;
        end else if (we && (idx < IW'(L))) begin
            regs[idx] <= data;
        end
    end

    for (genvar i = 0; i < S * S; i++) begin : g_a
        assign o_a[i] = regs[i];
    end
    for (genvar i = 0; i < S; i++) begin : g_bck
        assign o_b[i] = regs[OB + i];
        assign o_c[i] = regs[OC + i];
        assign o_k[i] = regs[OK + i];
    end

    assign o_x0 = regs[field_ofs(F_X0, S)];
    assign o_y0 = regs[field_ofs(F_Y0, S)];
    assign o_h0 = regs[field_ofs(F_H0, S)];

endmodule

// File: rtl/rk_host_if.sv
// Host-side loader for an RK solver: streams in a coefficient frame, runs the solver, streams back y and cycle count.
// Optional RK_HOST_CKSUM_EN appends an XOR checksum word; results held stable under m_ready backpressure.
module rk_host_if
    import rk_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int S     = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [WIDTH-1:0]        s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic signed [WIDTH-1:0] o_a [S*S],
    output logic signed [WIDTH-1:0] o_b [S],
    output logic signed [WIDTH-1:0] o_c [S],
    output logic signed [WIDTH-1:0] o_k [S],
    output logic signed [WIDTH-1:0] o_x0,
    output logic signed [WIDTH-1:0] o_y0,
    output logic signed [WIDTH-1:0] o_h0,
    output logic                    o_solver_rstn,
    input  logic                    i_finish_flag,
    input  logic signed [WIDTH-1:0] i_y,
    output logic                    o_busy,
    output logic                    o_cksum_err
);
    localparam int L = frame_len(S);
`ifdef RK_HOST_CKSUM_EN
    localparam int FL = L + 1;
`else
    localparam int FL = L;
`endif
    localparam int WCW = $clog2(FL + 1);
    localparam logic [WCW-1:0] LAST  = WCW'(FL - 1);
    localparam logic [WCW-1:0] LDATA = WCW'(L);

    rk_state_e        state, state_nxt;
    logic [WCW-1:0]   wcnt;
    logic [WIDTH-1:0] rcnt, ry, rc;
    logic             init_done;
    logic             take, last_word, cksum_ok;

    // s_ready stays low until the first edge after reset release
    assign s_ready       = (state == LOAD) && init_done;
    assign take          = s_valid && s_ready;
    assign last_word     = take && (wcnt == LAST);
    assign o_solver_rstn = (state != LOAD);
    assign o_busy        = (state != LOAD);
    assign m_valid       = (state == SEND_Y) || (state == SEND_CNT);

`ifdef RK_HOST_CKSUM_EN
    logic [WIDTH-1:0] xacc;
    logic             cksum_err_q;

    assign cksum_ok    = (s_data == xacc);
    assign o_cksum_err = cksum_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xacc        <= '0;
            cksum_err_q <= 1'b0;
        end else begin
            if (take) xacc <= last_word ? '0 : (xacc ^ s_data);
            cksum_err_q <= last_word && !cksum_ok;
        end
    end
`else
    assign cksum_ok    = 1'b1;
    assign o_cksum_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        m_data    = '0;
        case (state)
            LOAD:     if (last_word && cksum_ok) state_nxt = RUN;
            RUN:      if (i_finish_flag) state_nxt = SEND_Y;
            SEND_Y: begin
                m_data = ry;
                if (m_ready) state_nxt = SEND_CNT;
            end
            SEND_CNT: begin
                m_data = rc;
                if (m_ready) state_nxt = LOAD;
            end
            default:  state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= LOAD;
            init_done <= 1'b0;
            wcnt      <= '0;
            rcnt      <= '0;
            ry        <= '0;
            rc        <= '0;
        end else begin
            state     <= state_nxt;
            init_done <= 1'b1;
            if (state != LOAD || last_word) wcnt <= '0;
            else if (take)                  wcnt <= wcnt + 1'b1;
            // rcnt rests at zero outside RUN, so RUN entry always starts from 0
            if (state != RUN)    rcnt <= '0;
            else if (rcnt != '1) rcnt <= rcnt + 1'b1;
            if (state == RUN && i_finish_flag) begin
                ry <= i_y;
                rc <= rcnt;
            end
        end
    end

    rk_cfg_bank #(.WIDTH(WIDTH), .S(S), .IW(WCW)) u_bank (
        .clk  (clk),
        .rstn (rstn),
        .we   (take && (wcnt != LDATA)),
        .idx  (wcnt),
        .data (s_data),
        .o_a  (o_a),
        .o_b  (o_b),
        .o_c  (o_c),
        .o_k  (o_k),
        .o_x0 (o_x0),
        .o_y0 (o_y0),
        .o_h0 (o_h0)
    );

endmodule
